// File: rtl/button_debouncer_multi.sv
// rtl/button_debouncer_multi.sv - independent per-channel button debouncer with press/release/long/repeat pulses
module button_debouncer_multi #(
  parameter int NUM_BTNS       = 4,
  parameter int DEBOUNCE_LIMIT = 1_000_000,
  parameter int LONG_LIMIT     = 100_000_000,
  parameter int REPEAT_PERIOD  = 20_000_000,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_BTNS-1:0] i_btn,
  output logic [NUM_BTNS-1:0] o_debounced,
  output logic [NUM_BTNS-1:0] o_press,
  output logic [NUM_BTNS-1:0] o_release,
  output logic [NUM_BTNS-1:0] o_long,
  output logic [NUM_BTNS-1:0] o_repeat
);

  localparam int DW       = $clog2(DEBOUNCE_LIMIT);
  localparam int HOLD_MAX = (LONG_LIMIT > REPEAT_PERIOD) ? LONG_LIMIT : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_LIMIT - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit            REP_EN    = (REPEAT_PERIOD > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } hold_state_e;

  logic [NUM_BTNS-1:0] btn_pol;
  assign btn_pol = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          toggle;
    logic          press_q, release_q, long_q, repeat_q;
    logic [HW-1:0] hold_cnt_q;
    hold_state_e   state_q;

    // A level change is accepted only once the count of differing cycles is exhausted.
    always_comb begin
      toggle   = (sync2_q != deb_q) && (db_cnt_q == DB_LAST);
      deb_d    = deb_q ^ toggle;
      db_cnt_d = ((sync2_q == deb_q) || toggle) ? '0 : db_cnt_q + DW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        deb_q     <= 1'b0;
        db_cnt_q  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= btn_pol[g];
        sync2_q   <= sync1_q;
        deb_q     <= deb_d;
        db_cnt_q  <= db_cnt_d;
        press_q   <= toggle && !deb_q;
        release_q <= toggle && deb_q;
      end
    end

    // A debounced fall overrides any long/repeat that would land on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
        if (toggle && deb_q) begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
        end else if (toggle) begin
          state_q    <= ST_HELD;
          hold_cnt_q <= '0;
        end else begin
          case (state_q)
            ST_HELD: begin
              if (hold_cnt_q == LONG_LAST) begin
                state_q    <= ST_LONG;
                long_q     <= 1'b1;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + HW'(1);
              end
            end
            ST_LONG: begin
              if (REP_EN) begin
                if (hold_cnt_q == REP_LAST) begin
                  repeat_q   <= 1'b1;
                  hold_cnt_q <= '0;
                end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
                end
              end
            end
            default: begin
              state_q    <= ST_IDLE;
              hold_cnt_q <= '0;
            end
          endcase
        end
      end
    end

    assign o_debounced[g] = deb_q;
    assign o_press[g]     = press_q;
    assign o_release[g]   = release_q;
    assign o_long[g]      = long_q;
    assign o_repeat[g]    = repeat_q;
  end

endmodule

// File: doc/button_debouncer_multi.md
BUTTON_DEBOUNCER_MULTI -- requirements
Module: button_debouncer_multi

Interface
REQ-001 SHALL provide parameter NUM_BTNS, default 4: number of independent button channels (1..32).
REQ-002 SHALL provide parameter DEBOUNCE_LIMIT, default 1_000_000: consecutive stable cycles required to accept a level change (>=2).
REQ-003 SHALL provide parameter LONG_LIMIT, default 100_000_000: cycles the debounced level must stay high before a long-press event is flagged (> DEBOUNCE_LIMIT).
REQ-004 SHALL provide parameter REPEAT_PERIOD, default 20_000_000: auto-repeat pulse spacing after a long press (>=2); 0 disables auto-repeat.
REQ-005 SHALL provide parameter ACTIVE_LOW, default 0: when 1, i_btn is inverted before synchronisation, so a pressed button reads as 1 internally.
REQ-006 i_clk  input  1  system clock, all logic on the rising edge; one clock only.
REQ-007 i_rst  input  1  reset, asynchronous and active-high.
REQ-008 i_btn  input  NUM_BTNS  raw, asynchronous, bouncing button levels.
REQ-009 o_debounced  output  NUM_BTNS  stable filtered level per channel.
REQ-010 o_press  output  NUM_BTNS  one-cycle pulse on each debounced 0->1 transition.
REQ-011 o_release  output  NUM_BTNS  one-cycle pulse on each debounced 1->0 transition.
REQ-012 o_long  output  NUM_BTNS  one-cycle pulse when a press reaches LONG_LIMIT.
REQ-013 o_repeat  output  NUM_BTNS  one-cycle pulse every REPEAT_PERIOD cycles after o_long while still held.

Function
REQ-014 Each channel SHALL be fully independent, with no shared counters or arbitration.
REQ-015 Each channel SHALL pass its polarity-corrected input through a 2-flop synchronizer; only the second flop (sync) feeds later logic.
REQ-016 Debounce counter, width $clog2(DEBOUNCE_LIMIT): clears on any edge where sync == o_debounced, increments where they differ.
- When count == DEBOUNCE_LIMIT-1 and the inputs still differ, o_debounced SHALL toggle and the counter SHALL clear on that edge.
REQ-017 Latency: after i_btn settles before edge k, o_debounced SHALL change at edge k+DEBOUNCE_LIMIT+1, i.e. DEBOUNCE_LIMIT+2 edges after settling.
REQ-018 Any glitch shorter than DEBOUNCE_LIMIT synchronized cycles SHALL leave o_debounced unchanged and SHALL restart the count.
REQ-019 o_press and o_release SHALL be registered and asserted for exactly the one cycle following the o_debounced toggle edge; they SHALL never be asserted together on one channel.
REQ-020 Per-channel hold FSM, states IDLE, HELD, LONG:
- IDLE->HELD on a debounced rise, hold counter cleared.
- HELD: hold counter increments each cycle; at count == LONG_LIMIT-1, go to LONG, pulse o_long, clear the counter.
- LONG: counter counts to REPEAT_PERIOD-1, then pulses o_repeat and wraps to 0; no pulses when REPEAT_PERIOD == 0.
- Any state->IDLE on a debounced fall; a pending o_long/o_repeat SHALL NOT fire on that cycle.
REQ-021 o_long SHALL occur exactly LONG_LIMIT cycles after the corresponding o_press; first o_repeat exactly REPEAT_PERIOD cycles after o_long.
REQ-022 Hold and debounce counters SHALL saturate or wrap only as stated; no counter overflow SHALL be reachable for legal parameters.
REQ-023 Simultaneous activity on different channels SHALL produce concurrent pulses in the same cycle.

Reset
REQ-024 When i_rst is asserted, all synchronizer flops, counters, o_debounced, o_press, o_release, o_long and o_repeat SHALL clear to 0 immediately, without waiting for a clock edge, and all FSMs SHALL return to IDLE.
REQ-025 If reset is asserted mid-press, deasserting it with the button still held SHALL be treated as a new press, with full debounce latency before o_press.
REQ-026 All outputs SHALL hold 0 for as long as i_rst is high.

Verification (NUM_BTNS=4, DEBOUNCE_LIMIT=10, LONG_LIMIT=50, REPEAT_PERIOD=20, 10 ns clock)
REQ-027 Bounce test: ch0 toggles 1/0 every 20 ns for 80 ns, then held 1 -> no pulse during bounce; o_press[0] exactly once, 12 edges after the final rise; o_debounced[0]=1.
REQ-028 Release test: 60 ns of bounce, then held 0 -> single o_release[0] pulse; no spurious o_press.
REQ-029 Long/repeat test: ch1 held 1000 ns -> o_long[1] 50 cycles after o_press[1], then o_repeat[1] every 20 cycles; none after release.
REQ-030 Glitch test: 9-cycle high pulse on ch2 -> o_debounced[2] stays 0; no pulses.
REQ-031 Concurrency/reset test: ch0 and ch3 pressed on the same edge -> o_press=4'b1001 in one cycle; i_rst asserted between clock edges while held -> all outputs 0 immediately; after release of reset, a new o_press follows 12 edges later.
REQ-032 Polarity test: ACTIVE_LOW=1 with i_btn idle at 4'hF -> no press; driving ch0 low SHALL produce o_press[0].
